// File: rtl/ap_ctrl_driver.sv
// Drives an ap_ctrl_chain style accelerator: issues ap_start up to a programmed
// transaction count, acknowledges ap_done with optional back-pressure, and measures latency.
module ap_ctrl_driver #(
    parameter int CNT_W = 16,
    parameter int LAT_W = 32,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_go,
    input  logic [CNT_W-1:0] cfg_num_txn,
    input  logic [7:0]       cfg_cont_stall,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             ap_start,
    output logic             ap_continue,
    output logic             busy,
    output logic             finish,
    output logic [CNT_W-1:0] started_cnt,
    output logic [CNT_W-1:0] done_cnt,
    output logic [LAT_W-1:0] last_lat,
    output logic [LAT_W-1:0] max_lat,
    output logic             err_spurious
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] num_txn;
    logic [7:0]       cont_stall;
    logic [7:0]       stall_cnt;
    logic [LAT_W-1:0] cyc_cnt;
    logic [LAT_W-1:0] ts_mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0] outstanding;
    logic [LAT_W-1:0] lat_new;
    logic             active;
    logic             go_acc, start_acc, done_acc, done_ok, done_bad;

    assign active      = (state == RUN) || (state == DRAIN);
    assign outstanding = started_cnt - done_cnt;

    // Both handshakes depend only on registered state, so the accelerator
    // never sees a combinational path from its own ready/done.
    assign ap_start    = (state == RUN) && (started_cnt < num_txn) && (outstanding < DEPTH_C);
    assign ap_continue = active && (stall_cnt == 8'd0);
    assign busy        = active;
    assign finish      = (state == FIN);

    assign go_acc    = (state == IDLE) && cfg_go;
    assign start_acc = ap_start && ap_ready;
    assign done_acc  = ap_done && ap_continue;
    assign done_ok   = done_acc && (outstanding != '0);
    assign done_bad  = done_acc && (outstanding == '0);
    assign lat_new   = cyc_cnt - ts_mem[rd_ptr];

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (cfg_go)
                    state_nxt = (cfg_num_txn == '0) ? FIN : RUN;
            end
            RUN: begin
                if (start_acc && (started_cnt + ONE_C == num_txn))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (done_ok && (done_cnt + ONE_C == num_txn))
                    state_nxt = FIN;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            num_txn    <= '0;
            cont_stall <= '0;
        end else if (go_acc) begin
            num_txn    <= cfg_num_txn;
            cont_stall <= cfg_cont_stall;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cyc_cnt <= '0;
        else        cyc_cnt <= cyc_cnt + LAT_W'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            started_cnt <= '0;
            done_cnt    <= '0;
        end else if (go_acc) begin
            started_cnt <= '0;
            done_cnt    <= '0;
        end else begin
            if (start_acc) started_cnt <= started_cnt + ONE_C;
            if (done_ok)   done_cnt    <= done_cnt + ONE_C;
        end
    end

    // A done is only accepted while the counter is zero, so load and
    // decrement never collide.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            stall_cnt <= '0;
        else if (go_acc)
            stall_cnt <= '0;
        else if (done_acc && (cont_stall != 8'd0))
            stall_cnt <= cont_stall;
        else if (stall_cnt != 8'd0)
            stall_cnt <= stall_cnt - 8'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (go_acc) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (start_acc) wr_ptr <= wr_ptr + AW'(1);
            if (done_ok)   rd_ptr <= rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (start_acc) ts_mem[wr_ptr] <= cyc_cnt;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_lat     <= '0;
            max_lat      <= '0;
            err_spurious <= 1'b0;
        end else if (go_acc) begin
            max_lat      <= '0;
            err_spurious <= 1'b0;
        end else begin
            if (done_ok) begin
                last_lat <= lat_new;
                if (lat_new > max_lat) max_lat <= lat_new;
            end
            if (done_bad) err_spurious <= 1'b1;
        end
    end

endmodule
